nrs_reader: RTL and testbench
=============================

NRS_READER -- requirements
Module: nrs_reader

Interface
REQ-001 Parameter DEPTH, default 16: number of NRS register-file lines.
REQ-002 Parameter ADDR_W, default $clog2(DEPTH): read-address width.
REQ-003 Parameter DATA_W, default 2: bits per NRS value (one QPSK pair).
REQ-004 Parameter BATCH, default 4: NRS values consumed per generator ready/ack cycle.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  reset; asynchronous, active-high.
REQ-007 new_frame  in  1  pulse; restart read pointer at line 0 for the new frame.
REQ-008 NRS_gen_ready  in  1  level; generator has written one batch.
REQ-009 est_ack  out  1  one-cycle pulse; batch fully consumed.
REQ-010 rd_en  out  1  read strobe to the NRS register file.
REQ-011 rd_addr  out  ADDR_W  register-file read address.
REQ-012 rd_data  in  DATA_W  register-file data, valid exactly 1 cycle after rd_en.
REQ-013 nrs_valid  out  1  nrs_data holds a value for the estimator.
REQ-014 nrs_data  out  DATA_W  NRS value to the estimator.
REQ-015 nrs_last  out  1  qualifies nrs_valid; final value of the batch.
REQ-016 nrs_ready  in  1  estimator accepts when nrs_valid & nrs_ready.

Function
REQ-017 FSM states: IDLE, FETCH, DRAIN, ACK.
REQ-018 IDLE -> FETCH when NRS_gen_ready=1; else stay.
REQ-019 FETCH: assert rd_en in any cycle where issued<BATCH and (buffered + in-flight)<2; -> DRAIN in the cycle the BATCH-th read is issued.
REQ-020 DRAIN -> ACK in the cycle the nrs_last value is accepted (nrs_valid & nrs_ready & nrs_last).
REQ-021 ACK: est_ack=1 for exactly that cycle; unconditional -> IDLE.
REQ-022 est_ack is never asserted outside ACK; NRS_gen_ready is not sampled in ACK, so the generator's one-cycle clear latency never retriggers a batch.
REQ-023 rd_addr increments by 1 after each rd_en and wraps from DEPTH-1 to 0.
REQ-024 rd_addr persists across batches within a frame; batch k starts at line (k*BATCH) mod DEPTH.
REQ-025 new_frame in IDLE clears rd_addr to 0 on the next edge.
REQ-026 new_frame outside IDLE sets a pending flag; rd_addr is cleared and the flag dropped on the IDLE entry edge. The current batch completes unaffected.
REQ-027 Output buffer: 2-entry FIFO; pushed with rd_data one cycle after each rd_en; popped on nrs_valid & nrs_ready.
REQ-028 nrs_valid = FIFO non-empty; nrs_data = FIFO head; both hold stable while nrs_valid & !nrs_ready.
REQ-029 Simultaneous push and pop leaves the FIFO count unchanged. Push to a full FIFO cannot occur, by REQ-019.
REQ-030 nrs_last=1 only on the head entry that is the BATCH-th of the batch; the tag is carried in the FIFO.
REQ-031 Read-to-output latency with nrs_ready held 1: first rd_en in cycle t gives nrs_valid in cycle t+2. Sustained throughput is 1 value per cycle.
REQ-032 Issued-read counter is 0..BATCH; it clears on IDLE->FETCH.

Reset
REQ-033 While rst=1: state=IDLE, rd_addr=0, rd_en=0, est_ack=0, nrs_valid=0, nrs_data=0, nrs_last=0, FIFO empty, counters 0, pending flag 0.
REQ-034 rst asserted mid-batch aborts immediately with no est_ack. After release the block waits in IDLE for NRS_gen_ready.

Verification
REQ-035 Reset, then NRS_gen_ready=1, nrs_ready=1, file lines 0..3 = 0,1,2,3 -> rd_addr 0,1,2,3 on consecutive cycles; nrs_data 0,1,2,3; nrs_last on the value 3; one est_ack pulse.
REQ-036 Four consecutive batches with no new_frame -> reads cover lines 0..15; the fifth batch reads lines 0..3 (wrap).
REQ-037 Backpressure: nrs_ready=0 for 5 cycles mid-batch -> at most 2 values buffered, nrs_data stable, no value lost or duplicated, est_ack only after the 4th accept.
REQ-038 new_frame pulse during DRAIN of a batch starting at line 8 -> that batch still reads lines 8..11 and is acked; the next batch starts at line 0.
REQ-039 NRS_gen_ready held high through ACK -> exactly one est_ack per batch and no extra FETCH from the stale ready level.
REQ-040 rst pulse in FETCH after 2 reads -> all outputs return to 0 asynchronously, no est_ack; the next batch starts at line 0.

Source files
------------

// File: rtl/nrs_reader_if.sv
// rtl/nrs_reader_if.sv - NRS reader bus: generator handshake, register-file read port, estimator stream.
interface nrs_reader_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 2
);
   logic              new_frame;
   logic              NRS_gen_ready;
   logic              est_ack;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              nrs_valid;
   logic [DATA_W-1:0] nrs_data;
   logic              nrs_last;
   logic              nrs_ready;

   modport master (
      input  new_frame, NRS_gen_ready, rd_data, nrs_ready,
      output est_ack, rd_en, rd_addr, nrs_valid, nrs_data, nrs_last
   );

   modport slave (
      output new_frame, NRS_gen_ready, rd_data, nrs_ready,
      input  est_ack, rd_en, rd_addr, nrs_valid, nrs_data, nrs_last
   );
endinterface

// File: rtl/nrs_reader.sv
// rtl/nrs_reader.sv - Reads one batch of NRS values per generator ready and streams them to the estimator.
module nrs_reader #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int DATA_W = 2,
   parameter int BATCH  = 4
) (
   input  logic          clk,
   input  logic          rst,
   nrs_reader_if.master  bus
);
   localparam int CNT_W = $clog2(BATCH + 1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, ACK} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  issued;
   logic              frame_pend;
   logic              inflight, inflight_last;
   logic [DATA_W-1:0] fifo_data [2];
   logic              fifo_last [2];
   logic              wr_ptr, rd_ptr;
   logic [1:0]        count;
   logic              pop, push, room, last_issue, accept_last;

   assign pop         = bus.nrs_valid & bus.nrs_ready;
   assign push        = inflight;
   assign last_issue  = (issued == CNT_W'(BATCH - 1));
   assign accept_last = pop & bus.nrs_last;
   // A pop this cycle frees a slot, which is what sustains one read per cycle.
   assign room        = ({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

   assign bus.nrs_valid = (count != 2'd0);
   assign bus.nrs_data  = fifo_data[rd_ptr];
   assign bus.nrs_last  = bus.nrs_valid & fifo_last[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.NRS_gen_ready) state_nxt = FETCH;
         FETCH:   if (bus.rd_en && last_issue) state_nxt = DRAIN;
         DRAIN:   if (accept_last) state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.rd_en   = 1'b0;
      bus.est_ack = 1'b0;
      case (state)
         FETCH:   bus.rd_en   = (issued < CNT_W'(BATCH)) && room;
         ACK:     bus.est_ack = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issued        <= '0;
         bus.rd_addr   <= '0;
         frame_pend    <= 1'b0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         wr_ptr        <= 1'b0;
         rd_ptr        <= 1'b0;
         count         <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            fifo_data[i] <= '0;
            fifo_last[i] <= 1'b0;
         end
      end else begin
         if (state == IDLE && state_nxt == FETCH) issued <= '0;
         else if (bus.rd_en)                      issued <= issued + CNT_W'(1);

         // A new frame seen mid-batch takes effect on the ACK->IDLE edge.
         if ((state == IDLE && bus.new_frame) || (state == ACK && (frame_pend || bus.new_frame)))
            bus.rd_addr <= '0;
         else if (bus.rd_en)
            bus.rd_addr <= (bus.rd_addr == ADDR_W'(DEPTH - 1)) ? '0 : bus.rd_addr + ADDR_W'(1);

         if (state == ACK)                          frame_pend <= 1'b0;
         else if (bus.new_frame && state != IDLE)   frame_pend <= 1'b1;

         inflight      <= bus.rd_en;
         inflight_last <= bus.rd_en & last_issue;

         if (push) begin
            fifo_data[wr_ptr] <= bus.rd_data;
            fifo_last[wr_ptr] <= inflight_last;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;

         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_nrs_reader.sv
// tb/tb_nrs_reader.sv - Scoreboard bench for nrs_reader with a line-pointer reference model.
module tb_nrs_reader;
   localparam int DEPTH = 16, ADDR_W = 4, DATA_W = 2, BATCH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   nrs_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

   nrs_reader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BATCH(BATCH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0, failures = 0;
   logic [DATA_W-1:0] file_mem [DEPTH];
   int model_ptr = 0;
   bit model_nf_pend = 0;
   int exp_addr[$], exp_data[$], exp_last[$];
   int cyc = 0, rd_total = 0, acc_total = 0, ack_count = 0, exp_acks = 0;
   int out_reads = 0, out_accs = 0, first_valid_cyc = -1;
   int rd_cyc[$];
   int ready_mode = 0;
   logic held_v = 1'b0;
   logic [DATA_W-1:0] held_d;
   logic held_l;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Register file: data appears the cycle after the read strobe.
   always @(posedge clk) begin
      cyc++;
      if (rst)            bus.rd_data <= '0;
      else if (bus.rd_en) bus.rd_data <= file_mem[bus.rd_addr];
   end

   initial begin
      bus.nrs_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       bus.nrs_ready = 1'b1;
            1:       bus.nrs_ready = 1'($urandom_range(0, 1));
            default: bus.nrs_ready = 1'b0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         out_reads = 0;
         out_accs  = 0;
         held_v    = 1'b0;
      end else begin
         if (bus.rd_en) begin
            check("outstanding_le_2", ((out_reads + 1) - (out_accs + int'(bus.nrs_valid & bus.nrs_ready))) <= 2, 1);
            if (exp_addr.size() == 0) check("unexpected_read_addr", bus.rd_addr, 32'hFFFF_FFFF);
            else                      check("rd_addr", bus.rd_addr, exp_addr.pop_front());
            rd_total++;
            out_reads++;
            rd_cyc.push_back(cyc);
         end
         if (bus.nrs_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (held_v) begin
            check("hold_valid", bus.nrs_valid, 1);
            check("hold_data", bus.nrs_data, held_d);
            check("hold_last", bus.nrs_last, held_l);
         end
         if (bus.nrs_valid && bus.nrs_ready) begin
            if (exp_data.size() == 0) check("unexpected_value", bus.nrs_data, 32'hFFFF_FFFF);
            else begin
               check("nrs_data", bus.nrs_data, exp_data.pop_front());
               check("nrs_last", bus.nrs_last, exp_last.pop_front());
            end
            acc_total++;
            out_accs++;
         end
         held_v = bus.nrs_valid & ~bus.nrs_ready;
         held_d = bus.nrs_data;
         held_l = bus.nrs_last;
         if (bus.est_ack) begin
            ack_count++;
            check("ack_after_last_accept", exp_data.size(), 0);
         end
      end
   end

   // Model: a batch reads BATCH consecutive lines from the frame pointer, modulo DEPTH.
   task automatic start_batch();
      for (int i = 0; i < BATCH; i++) begin
         int a;
         a = (model_ptr + i) % DEPTH;
         exp_addr.push_back(a);
         exp_data.push_back(int'(file_mem[a]));
         exp_last.push_back(i == BATCH - 1);
      end
      model_ptr = (model_ptr + BATCH) % DEPTH;
      bus.NRS_gen_ready = 1'b1;
   endtask

   task automatic wait_ack();
      int n = 0;
      while (!bus.est_ack && n < 300) begin
         tick();
         n++;
      end
      check("ack_seen", bus.est_ack, 1);
      @(posedge clk);
      #1;
      bus.NRS_gen_ready = 1'b0;
      exp_acks++;
      if (model_nf_pend) begin
         model_ptr = 0;
         model_nf_pend = 0;
      end
      repeat (3) tick();
      check("ack_count", ack_count, exp_acks);
   endtask

   task automatic wait_reads(input int target);
      int n = 0;
      while (rd_total < target && n < 100) begin
         tick();
         n++;
      end
      check("reads_reached", rd_total >= target, 1);
   endtask

   task automatic wait_accepts(input int target);
      int n = 0;
      while (acc_total < target && n < 100) begin
         tick();
         n++;
      end
      check("accepts_reached", acc_total >= target, 1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_rd_en"}, bus.rd_en, 0);
      check({tag, "_est_ack"}, bus.est_ack, 0);
      check({tag, "_nrs_valid"}, bus.nrs_valid, 0);
      check({tag, "_nrs_data"}, bus.nrs_data, 0);
      check({tag, "_nrs_last"}, bus.nrs_last, 0);
      check({tag, "_rd_addr"}, bus.rd_addr, 0);
   endtask

   initial begin
      int acks_before;
      foreach (file_mem[i]) file_mem[i] = DATA_W'($urandom);
      bus.NRS_gen_ready = 1'b0;
      bus.new_frame = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      check_idle_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Basic batch: lines 0..3 hold 0..3, estimator always ready.
      for (int i = 0; i < BATCH; i++) file_mem[i] = DATA_W'(i);
      ready_mode = 0;
      rd_cyc.delete();
      first_valid_cyc = -1;
      start_batch();
      wait_ack();
      check("latency_rd_to_valid", first_valid_cyc - rd_cyc[0], 2);
      check("reads_back_to_back", rd_cyc[BATCH-1] - rd_cyc[0], BATCH - 1);

      // Four more batches with random backpressure: covers lines 4..15 then wraps to 0..3.
      ready_mode = 1;
      for (int b = 0; b < 4; b++) begin
         foreach (file_mem[i]) file_mem[i] = DATA_W'($urandom);
         start_batch();
         wait_ack();
      end
      check("addr_queue_drained", exp_addr.size(), 0);

      // Five cycles of stall after the first accept.
      ready_mode = 0;
      foreach (file_mem[i]) file_mem[i] = DATA_W'($urandom);
      start_batch();
      wait_accepts(acc_total + 1);
      ready_mode = 2;
      repeat (5) tick();
      ready_mode = 0;
      wait_ack();

      // New frame during DRAIN of the batch at line 8; ready stays high through ACK.
      check("model_at_line_8", model_ptr, 8);
      start_batch();
      wait_reads(rd_total + BATCH);
      tick();
      bus.new_frame = 1'b1;
      model_nf_pend = 1;
      tick();
      bus.new_frame = 1'b0;
      wait_ack();
      start_batch();
      wait_ack();

      // New frame while idle.
      bus.new_frame = 1'b1;
      tick();
      bus.new_frame = 1'b0;
      model_ptr = 0;
      tick();
      start_batch();
      wait_ack();

      // Reset after two reads of a batch.
      start_batch();
      wait_reads(rd_total + 2);
      acks_before = ack_count;
      #2 rst = 1'b1;
      #1;
      check_idle_outputs("abort");
      bus.NRS_gen_ready = 1'b0;
      exp_addr.delete();
      exp_data.delete();
      exp_last.delete();
      model_ptr = 0;
      model_nf_pend = 0;
      repeat (3) tick();
      @(negedge clk);
      rst = 1'b0;
      repeat (3) tick();
      check("no_ack_after_abort", ack_count, acks_before);
      exp_acks = ack_count;

      ready_mode = 1;
      for (int b = 0; b < 3; b++) begin
         foreach (file_mem[i]) file_mem[i] = DATA_W'($urandom);
         start_batch();
         wait_ack();
      end
      check("final_queue_empty", exp_data.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end
endmodule
